// File: rtl/ws2812_led_driver.sv
// Wishbone-mapped WS2812 strip driver: a pixel buffer serialised MSB-first (GRB) onto one data line,
// followed by a low latch gap, with a sticky DONE flag and a level interrupt.
module ws2812_led_driver #(
  parameter int unsigned MAX_LEDS = 64,
  parameter int unsigned T0H      = 16,
  parameter int unsigned T1H      = 32,
  parameter int unsigned TBIT     = 50,
  parameter int unsigned TRST     = 2400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        led_o,
  output logic        irq
);

  localparam int unsigned IdxW   = (MAX_LEDS > 1) ? $clog2(MAX_LEDS) : 1;
  localparam int unsigned CntMax = (TRST > TBIT) ? TRST : TBIT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] T0hC     = CntW'(T0H);
  localparam logic [CntW-1:0] T1hC     = CntW'(T1H);
  localparam logic [CntW-1:0] TbitLast = CntW'(TBIT - 1);
  localparam logic [CntW-1:0] TrstLast = CntW'(TRST - 1);
  localparam logic [7:0]      MaxLeds  = 8'(MAX_LEDS);
  localparam logic [IdxW-1:0] IdxZero  = '0;

  typedef enum logic [1:0] {StIdle, StBit, StLatch} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      bit_q, bit_d;
  logic [7:0]      pix_q, pix_d;
  logic [23:0]     shift_q, shift_d;
  logic            led_q, led_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic            irq_en_q, irq_en_d;
  logic            done_q, done_d;
  logic [7:0]      num_q, num_d;

  logic [23:0] mem [MAX_LEDS];

  logic            req, wr, is_pix, busy, start, done_set, w1c;
  logic [5:0]      reg_off;
  logic [6:0]      adr_idx;
  logic [IdxW-1:0] buf_idx;
  logic [7:0]      pix_nxt, num_last;
  logic [CntW-1:0] thigh;
  logic            unused_ok;

  assign req     = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr      = req & wbs_we_i;
  assign is_pix  = wbs_adr_i[8];
  assign reg_off = wbs_adr_i[7:2];
  assign adr_idx = {1'b0, wbs_adr_i[7:2]};
  assign buf_idx = adr_idx[IdxW-1:0];
  assign busy    = (state_q != StIdle);
  assign pix_nxt = pix_q + 8'd1;
  assign num_last = num_q - 8'd1;
  assign thigh   = shift_q[23] ? T1hC : T0hC;

  assign start = wr & ~is_pix & (reg_off == 6'd0) & wbs_sel_i[0] & wbs_dat_i[0] & ~busy &
                 (num_q != 8'd0);
  assign w1c   = wr & ~is_pix & (reg_off == 6'd1) & wbs_dat_i[1];

  assign unused_ok = ^{wbs_adr_i[31:9], wbs_adr_i[1:0], wbs_dat_i[31:24]};

  // Pixel buffer deliberately has no reset.
  always_ff @(posedge clk) begin
    if (wr && is_pix) begin
      if (wbs_sel_i[0]) mem[buf_idx][7:0]   <= wbs_dat_i[7:0];
      if (wbs_sel_i[1]) mem[buf_idx][15:8]  <= wbs_dat_i[15:8];
      if (wbs_sel_i[2]) mem[buf_idx][23:16] <= wbs_dat_i[23:16];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    pix_d    = pix_q;
    shift_d  = shift_q;
    done_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StBit;
          cnt_d   = '0;
          bit_d   = '0;
          pix_d   = '0;
          shift_d = mem[IdxZero];
        end
      end
      StBit: begin
        if (cnt_q == TbitLast) begin
          cnt_d = '0;
          if (bit_q == 5'd23) begin
            bit_d = '0;
            if (pix_q == num_last) begin
              state_d = StLatch;
            end else begin
              // Next pixel is fetched at load time so late buffer writes are honoured.
              pix_d   = pix_nxt;
              shift_d = mem[pix_nxt[IdxW-1:0]];
            end
          end else begin
            bit_d   = bit_q + 5'd1;
            shift_d = {shift_q[22:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLatch: begin
        if (cnt_q == TrstLast) begin
          state_d  = StIdle;
          cnt_d    = '0;
          done_set = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    led_d    = (state_q == StBit) && (cnt_q < thigh);
    ack_d    = req;
    irq_en_d = irq_en_q;
    num_d    = num_q;
    done_d   = done_set | (done_q & ~w1c);
    dat_d    = '0;
    if (wr && !is_pix && wbs_sel_i[0]) begin
      if (reg_off == 6'd0) irq_en_d = wbs_dat_i[1];
      if (reg_off == 6'd2 && !busy) begin
        num_d = (wbs_dat_i[7:0] > MaxLeds) ? MaxLeds : wbs_dat_i[7:0];
      end
    end
    if (req && !wbs_we_i) begin
      if (is_pix) begin
        dat_d = {8'h00, mem[buf_idx]};
      end else begin
        unique case (reg_off)
          6'd0:    dat_d = {30'd0, irq_en_q, 1'b0};
          6'd1:    dat_d = {30'd0, done_q, busy};
          6'd2:    dat_d = {24'd0, num_q};
          default: dat_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      pix_q    <= '0;
      shift_q  <= '0;
      led_q    <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      num_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      pix_q    <= pix_d;
      shift_q  <= shift_d;
      led_q    <= led_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      num_q    <= num_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign led_o     = led_q;
  assign irq       = done_q & irq_en_q;

endmodule

// File: tb/tb_ws2812_led_driver.sv
// Directed bench for ws2812_led_driver: register map, bit timing, frame length, DONE/irq and reset.
module tb_ws2812_led_driver;

  localparam int MAX_LEDS = 64;
  localparam int T0H  = 16;
  localparam int T1H  = 32;
  localparam int TBIT = 50;
  localparam int TRST = 2400;
  localparam int ONE_FRAME = 24 * TBIT + TRST;

  localparam logic [31:0] A_CTRL = 32'h000;
  localparam logic [31:0] A_STAT = 32'h004;
  localparam logic [31:0] A_NUM  = 32'h008;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat_w = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dat_r;
  logic        ack, led, irq;

  int total = 0;
  int bad = 0;
  int wide = 0;
  logic ack_prev = 1'b0;

  ws2812_led_driver #(
    .MAX_LEDS(MAX_LEDS), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRST(TRST)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_adr_i(adr),
    .wbs_sel_i(sel),
    .wbs_dat_i(dat_w),
    .wbs_dat_o(dat_r),
    .wbs_ack_o(ack),
    .led_o    (led),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (ack && ack_prev) wide++;
    ack_prev = ack;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, output logic [31:0] rdat);
    int n;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 8);
    chk("ack_seen", {31'd0, ack}, 32'd1);
    rdat = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    wb(1'b1, a, d, 4'hF, r);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    wb(1'b0, a, 32'h0, 4'hF, r);
    chk(tag, r, exp);
  endtask

  // Entered one step after the START ack edge; sample k follows edge k+1 of the frame.
  task automatic frame_check(input string tag, input int nbits, input logic [95:0] bits,
                             input logic exp_irq);
    int total_c, run, extra, latch_ones, irq_early, p, exp_h;
    logic seen_low;
    total_c = nbits * TBIT + TRST;
    run = 0; extra = 0; seen_low = 1'b0; latch_ones = 0; irq_early = 0;
    chk({tag, "_led_at_ack"}, {31'd0, led}, 32'd0);
    for (int k = 0; k < total_c; k++) begin
      @(posedge clk); #1;
      if (k < nbits * TBIT) begin
        p = k % TBIT;
        if (p == 0) begin run = 0; extra = 0; seen_low = 1'b0; end
        if (led) begin
          if (seen_low) extra++; else run++;
        end else begin
          seen_low = 1'b1;
        end
        if (p == TBIT - 1) begin
          exp_h = bits[95 - k / TBIT] ? T1H : T0H;
          chk($sformatf("%s_bit%0d_high", tag, k / TBIT), run + 1000 * extra, exp_h);
        end
      end else if (led) begin
        latch_ones++;
      end
      if (k < total_c - 1 && irq) irq_early++;
    end
    chk({tag, "_latch_low"}, latch_ones, 0);
    chk({tag, "_irq_early"}, irq_early, 0);
    chk({tag, "_irq_end"}, {31'd0, irq}, {31'd0, exp_irq});
  endtask

  initial begin
    logic [31:0] r;
    longint t0;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_led", {31'd0, led}, 0);
    chk("rst_ack", {31'd0, ack}, 0);
    chk("rst_dat", dat_r, 0);
    chk("rst_irq", {31'd0, irq}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rd("rst_ctrl", A_CTRL, 0);
    rd("rst_stat", A_STAT, 0);
    rd("rst_num", A_NUM, 0);

    // START with NUM_LEDS=0 is ignored
    wr(A_CTRL, 32'h1);
    rd("start0_stat", A_STAT, 0);
    repeat (10) @(posedge clk);
    rd("start0_stat_late", A_STAT, 0);

    // Register and buffer access
    wr(A_NUM, 32'd200);
    rd("num_clamp", A_NUM, 32'd64);
    wb(1'b1, A_NUM, 32'd5, 4'h0, r);
    rd("num_sel0", A_NUM, 32'd64);
    wr(32'h114, 32'hAA12_3456);
    rd("pix5", 32'h114, 32'h0012_3456);
    wb(1'b1, 32'h114, 32'hFFFF_99FF, 4'b0010, r);
    rd("pix5_sel", 32'h114, 32'h0012_9956);
    rd("pix5_hiadr", 32'hFFFF_F114, 32'h0012_9956);
    rd("off_0c", 32'h00C, 0);

    // Single LED, IRQ_EN=0
    wr(A_NUM, 32'd1);
    wr(32'h100, 32'h0080_0001);
    wr(A_CTRL, 32'h1);
    frame_check("one", 24, {24'h800001, 72'h0}, 1'b0);
    rd("one_stat", A_STAT, 32'h2);
    wr(A_CTRL, 32'h2);
    chk("irq_en_on", {31'd0, irq}, 1);
    rd("ctrl_rd", A_CTRL, 32'h2);
    wr(A_STAT, 32'h2);
    chk("w1c_irq", {31'd0, irq}, 0);
    rd("w1c_stat", A_STAT, 0);

    // Three LEDs back to back
    wr(A_NUM, 32'd3);
    wr(32'h100, 32'h00A5_C30F);
    wr(32'h104, 32'h003C_5AF0);
    wr(32'h108, 32'h000F_00FF);
    wr(A_CTRL, 32'h3);
    frame_check("multi", 72, {24'hA5C30F, 24'h3C5AF0, 24'h0F00FF, 24'h0}, 1'b1);
    rd("multi_stat", A_STAT, 32'h2);
    wr(A_STAT, 32'h2);

    // START and NUM_LEDS writes while busy are ignored
    wr(A_NUM, 32'd1);
    wr(A_CTRL, 32'h3);
    t0 = $time;
    repeat (100) @(posedge clk);
    wr(A_CTRL, 32'h3);
    wr(A_NUM, 32'd5);
    rd("num_busy", A_NUM, 32'd1);
    rd("busy_stat", A_STAT, 32'h1);
    n = 0;
    while (!irq && n < 2 * ONE_FRAME) begin
      @(posedge clk); #1; n++;
    end
    chk("restart_len", 32'(($time - t0) / 10), ONE_FRAME);
    wr(A_STAT, 32'h2);

    // W1C landing on the same edge that sets DONE
    wr(A_CTRL, 32'h3);
    repeat (ONE_FRAME - 1) @(posedge clk);
    wr(A_STAT, 32'h2);
    chk("w1c_race_irq", {31'd0, irq}, 1);
    rd("w1c_race_stat", A_STAT, 32'h2);
    wr(A_STAT, 32'h2);

    // Reset during pixel 1
    wr(A_NUM, 32'd3);
    wr(A_CTRL, 32'h3);
    repeat (24 * TBIT + 10) @(posedge clk);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!led && n < 2 * TBIT);
    chk("rst_mid_led_hi", {31'd0, led}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_led_lo", {31'd0, led}, 0);
    chk("rst_mid_irq", {31'd0, irq}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rd("rst_mid_stat", A_STAT, 0);
    rd("rst_mid_num", A_NUM, 0);
    rd("rst_mid_ctrl", A_CTRL, 0);
    repeat (ONE_FRAME) @(posedge clk);
    rd("rst_mid_stat_late", A_STAT, 0);

    chk("ack_width", wide, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ws2812_led_driver.md
# ws2812_led_driver

Wishbone-mapped serial LED strip driver, downstream of `nec_ir_receiver` in the Christmas tree controller. Firmware reads decoded IR commands from the receiver, then writes per-LED GRB colours into this block's pixel buffer and triggers a refresh. The block serialises the buffer onto a single WS2812 data line with exact bit timing, then holds the latch/reset gap. It flags completion through a sticky status bit and an interrupt.

## Interface
- `MAX_LEDS`, 64: pixel buffer depth. Must be a power of 2, ≤128.
- `T0H`, 16: clocks high for a 0 bit (0.4 µs at 40 MHz).
- `T1H`, 32: clocks high for a 1 bit (0.8 µs).
- `TBIT`, 50: total clocks per bit (1.25 µs). Constraint: T0H < T1H < TBIT.
- `TRST`, 2400: clocks low after the frame (60 µs latch).

Ports:
- `clk` in 1: sole clock (wb_clk_i).
- `rst_n` in 1: asynchronous active-low reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1: Wishbone classic control.
- `wbs_adr_i` in 32: byte address. Only [8:2] is decoded; upper bits are decoded outside this block.
- `wbs_sel_i` in 4: byte enables.
- `wbs_dat_i` in 32: write data.
- `wbs_dat_o` out 32: read data. 0 when not acking.
- `wbs_ack_o` out 1: single-cycle registered acknowledge.
- `led_o` out 1: WS2812 serial data.
- `irq` out 1: level interrupt, = DONE & IRQ_EN.

## Operation
- **Register map**, word offsets, adr[8]=0:
  - 0x00 CTRL: bit0 START (write-1 pulse; reads 0); bit1 IRQ_EN (R/W).
  - 0x04 STATUS: bit0 BUSY (RO); bit1 DONE (sticky; write 1 clears).
  - 0x08 NUM_LEDS: [7:0]. Writes above MAX_LEDS store MAX_LEDS.
  - Other offsets read 0 and ignore writes.
- **Pixel buffer**: adr[8]=1, index = adr[7:2] mod MAX_LEDS.
  - Word [23:0] = G[23:16], R[15:8], B[7:0]; [31:24] read 0.
  - wbs_sel_i is honoured per byte for pixel writes and for CTRL/NUM_LEDS byte 0.
  - Buffer is not reset; contents are undefined until written.
- **FSM** states: IDLE, BIT, LATCH.
  - IDLE→BIT on START=1 with NUM_LEDS≠0. On entry: shift register ← pixel[0], bit count 0, pixel index 0.
  - START is ignored when BUSY=1 or NUM_LEDS=0. With NUM_LEDS=0, DONE is not set.
  - BIT: `led_o`=1 for T0H or T1H clocks (per shift MSB), then 0 until TBIT clocks have elapsed.
    - At bit end, shift left.
    - After bit 23, load the next pixel with no gap.
    - After bit 23 of pixel NUM_LEDS-1, go to LATCH.
  - LATCH: `led_o`=0 for TRST clocks, then IDLE with DONE←1.
  - BUSY = (state≠IDLE).
- Writes to NUM_LEDS while BUSY are ignored.
- Pixel writes while BUSY are accepted. A pixel not yet loaded into the shift register is sent with its new value.
- Same-cycle DONE set and W1C: set wins.

## Timing
- **Reset values**: `led_o`=0, `wbs_ack_o`=0, `wbs_dat_o`=0, `irq`=0, state IDLE, IRQ_EN=0, DONE=0, NUM_LEDS=0.
- **Wishbone handshake**:
  - Request = cyc&stb&~ack. `wbs_ack_o` rises on the next edge for one cycle.
  - Writes take effect on that same edge; read data is valid while ack=1.
  - Back-to-back requests give one ack every 2 cycles.
- **Latency**: `led_o` first rises on the edge after the START ack edge.
- **Frame length**: exactly NUM_LEDS×24×TBIT clocks of bits, then TRST clocks low.
- DONE and `irq` rise on the clock after the last LATCH cycle.
- Mid-frame `rst_n` assertion: `led_o` goes low immediately (asynchronously), all state returns to its reset value, and no DONE is set.

## Test plan
- **Register R/W**: write NUM_LEDS=200 → reads 64. Write pixel[5]=0xAA123456 → reads 0x00123456. Offset 0x0C reads 0. Every access gets exactly one ack pulse.
- **Single LED**: NUM_LEDS=1, pixel[0]=0x800001, START.
  - Bit 0 high 32 clocks; bits 1–22 high 16 clocks; bit 23 high 32 clocks; each bit period 50 clocks.
  - Then 2400 clocks low; DONE=1; `irq`=1 only if IRQ_EN=1.
- **Multi-LED continuity**: NUM_LEDS=3, distinct pixels.
  - Decoded 72 bits match G,R,B MSB-first, with no gap between pixels.
  - BUSY stays 1 for exactly 72×50+2400 clocks.
- **Ignored START**:
  - START with NUM_LEDS=0 → BUSY stays 0, DONE stays 0.
  - START during BUSY → frame length unchanged.
  - NUM_LEDS write during BUSY → value unchanged.
- **DONE/irq**: W1C on STATUS bit1 drops `irq` next cycle. W1C on the same cycle DONE is set → DONE stays 1.
- **Reset mid-frame**: assert `rst_n`=0 during pixel 1 → `led_o`=0 immediately. After release, BUSY=0, DONE=0, NUM_LEDS=0.
